wb_trace_buffer: RTL and testbench
==================================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC and write data.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 SHALL have parameter POST, default 4, events recorded after trigger in circular mode; 0 <= POST < DEPTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wb_valid  input  1  register-file write commits this cycle.
REQ-007 wb_waddr  input  5  destination register of the write.
REQ-008 wb_wdata  input  XLEN  value written.
REQ-009 wb_pc  input  XLEN  PC of the committing instruction.
REQ-010 arm  input  1  one-cycle pulse; clears buffer and starts a capture.
REQ-011 mode  input  1  0 = linear, 1 = circular; sampled on arm.
REQ-012 trig_en  input  1  1 = wait for PC match; 0 = trigger immediately on arm.
REQ-013 trig_pc  input  XLEN  trigger PC.
REQ-014 rd_ready  input  1  consumer accepts rd_data.
REQ-015 rd_valid  output  1  rd_data holds an unread entry.
REQ-016 rd_data  output  2*XLEN+5  {pc, waddr, wdata} of oldest unread entry.
REQ-017 count  output  $clog2(DEPTH+1)  entries currently held.
REQ-018 state  output  2  current FSM state (encoding per package).
REQ-019 overflow  output  1  sticky; at least one entry was overwritten since arm.

Function
REQ-020 A qualifying event SHALL be wb_valid=1 and wb_waddr!=0; x0 writes are never recorded and never trigger.
REQ-021 A trigger SHALL be a qualifying event with wb_pc==trig_pc when trig_en=1; the triggering event is itself recorded.
REQ-022 FSM states SHALL be IDLE, ARMED, CAPTURE, DONE.
REQ-023 IDLE: no recording; arm -> ARMED.
REQ-024 arm in any state SHALL clear count, pointers and overflow and enter ARMED next cycle; the arm-cycle event is not recorded; arm beats a simultaneous pop.
REQ-025 ARMED, linear: record nothing until trigger; trigger -> CAPTURE; trig_en=0 -> CAPTURE on first cycle in ARMED, first qualifying event recorded.
REQ-026 ARMED, circular: record every qualifying event; when count==DEPTH, overwrite oldest, count stays DEPTH, overflow=1; trigger -> CAPTURE with post counter=POST; trig_en=0 behaves as trigger on first qualifying event.
REQ-027 CAPTURE, linear: record each qualifying event; entering count==DEPTH -> DONE same edge; further events dropped.
REQ-028 CAPTURE, circular: each qualifying event recorded (overwriting when full) and decrements post counter; post counter reaching 0 -> DONE; POST=0 -> DONE on the trigger edge.
REQ-029 DONE: no recording; rd_valid = (count!=0); rd_data combinationally from read pointer.
REQ-030 Pop on rd_valid & rd_ready: read pointer +1 mod DEPTH, count -1; order oldest first; rd_valid=0 at count 0, state stays DONE.
REQ-031 rd_valid SHALL be 0 in IDLE, ARMED, CAPTURE.
REQ-032 Pointers SHALL wrap modulo DEPTH without gap or duplicate.

Reset
REQ-033 rst=1 SHALL force state=IDLE, count=0, pointers=0, post counter=0, overflow=0, rd_valid=0 immediately, independent of clk.
REQ-034 Storage array SHALL not be reset; rd_data is don't-care while rd_valid=0.
REQ-035 Reset mid-capture SHALL discard all contents; arm required to restart.

Structure
REQ-036 Package trace_pkg SHALL hold state enum, trace entry struct {pc, waddr, wdata}, and entry-width function of XLEN.
REQ-037 Storage SHALL be sub-module trace_ram: DEPTH x entry, one synchronous write port, one asynchronous read port.

Verification
REQ-038 DEPTH=4, linear, trig_en=0; arm, 6 events x1..x6 data 0x11..0x66 -> DONE after 4th, count=4, reads 0x11,0x22,0x33,0x44, overflow=0.
REQ-039 Linear, trig_pc=0x10; events at PC 0x08,0x0C,0x10,0x14 -> first entry PC 0x10, second 0x14, state CAPTURE, count=2.
REQ-040 DEPTH=4, POST=2, circular, trig_pc=0x20; 6 pre-trigger events, trigger, 2 post events -> DONE, count=4, overflow=1, read order: last pre-trigger, trigger, post1, post2.
REQ-041 wb_valid=1 with wb_waddr=0 at trig_pc -> not recorded, no trigger, count unchanged.
REQ-042 DONE, count=3, rd_ready=1 with arm same cycle -> no pop, next cycle ARMED, count=0, rd_valid=0.
REQ-043 rst pulsed asynchronously mid-CAPTURE, between clk edges -> state=IDLE, count=0 before next edge; events ignored until arm.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the writeback trace buffer: FSM encoding, entry layout and entry width.
package trace_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int unsigned TRACE_XLEN = 32;

   // Field order matches rd_data packing: {pc, waddr, wdata}.
   typedef struct packed {
      logic [TRACE_XLEN-1:0] pc;
      logic [4:0]            waddr;
      logic [TRACE_XLEN-1:0] wdata;
   } trace_entry_t;

   function automatic int unsigned entry_width(input int unsigned xlen);
      return 2 * xlen + 5;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH entries, one synchronous write port, one asynchronous read port.
module trace_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 69,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Register-file writeback trace buffer with PC trigger, linear or circular capture and FIFO readout.
module wb_trace_buffer
   import trace_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned POST  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wb_valid,
   input  logic [4:0]                 wb_waddr,
   input  logic [XLEN-1:0]            wb_wdata,
   input  logic [XLEN-1:0]            wb_pc,
   input  logic                       arm,
   input  logic                       mode,
   input  logic                       trig_en,
   input  logic [XLEN-1:0]            trig_pc,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [2*XLEN+4:0]          rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output state_t                     state,
   output logic                       overflow
);

   localparam int unsigned EW = entry_width(XLEN);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] post_cnt;
   logic          mode_q;
   logic          qual, hit, rec, full, pop;

   assign qual     = wb_valid && (wb_waddr != 5'd0);
   assign hit      = qual && trig_en && (wb_pc == trig_pc);
   assign full     = (count == CW'(DEPTH));
   assign rd_valid = (state == DONE) && (count != '0);
   assign pop      = rd_valid && rd_ready && !arm;

   always_comb begin
      rec = 1'b0;
      unique case (state)
         ARMED:   rec = qual && (mode_q || !trig_en || hit);
         CAPTURE: rec = qual;
         default: rec = 1'b0;
      endcase
      if (arm) rec = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         post_cnt <= '0;
         overflow <= 1'b0;
         mode_q   <= 1'b0;
      end else if (arm) begin
         state    <= ARMED;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         post_cnt <= '0;
         overflow <= 1'b0;
         mode_q   <= mode;
      end else begin
         if (rec) begin
            wr_ptr <= wr_ptr + 1'b1;
            // Only circular mode can record while full: drop the oldest entry.
            if (full) begin
               rd_ptr   <= rd_ptr + 1'b1;
               overflow <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
         end
         unique case (state)
            ARMED: begin
               if (!mode_q) begin
                  if (!trig_en || hit) state <= CAPTURE;
               end else if (qual && (!trig_en || hit)) begin
                  if (POST == 0) begin
                     state <= DONE;
                  end else begin
                     state    <= CAPTURE;
                     post_cnt <= CW'(POST);
                  end
               end
            end
            CAPTURE: begin
               if (qual) begin
                  if (!mode_q) begin
                     if (count == CW'(DEPTH - 1)) state <= DONE;
                  end else begin
                     post_cnt <= post_cnt - 1'b1;
                     if (post_cnt == CW'(1)) state <= DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (rec),
      .waddr (wr_ptr),
      .wdata ({wb_pc, wb_waddr, wb_wdata}),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer (DEPTH=4, POST=2): linear, triggered, circular, arm/pop and reset cases.
module tb_wb_trace_buffer;
   import trace_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned POST  = 2;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wb_valid = 1'b0;
   logic [4:0]        wb_waddr = '0;
   logic [XLEN-1:0]   wb_wdata = '0;
   logic [XLEN-1:0]   wb_pc = '0;
   logic              arm = 1'b0;
   logic              mode = 1'b0;
   logic              trig_en = 1'b0;
   logic [XLEN-1:0]   trig_pc = '0;
   logic              rd_ready = 1'b0;
   logic              rd_valid;
   logic [2*XLEN+4:0] rd_data;
   logic [CW-1:0]     count;
   state_t            state;
   logic              overflow;

   int n_checks = 0;
   int n_errors = 0;

   wb_trace_buffer #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .POST  (POST)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_valid (wb_valid),
      .wb_waddr (wb_waddr),
      .wb_wdata (wb_wdata),
      .wb_pc    (wb_pc),
      .arm      (arm),
      .mode     (mode),
      .trig_en  (trig_en),
      .trig_pc  (trig_pc),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .count    (count),
      .state    (state),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ev(input logic [31:0] pc, input logic [4:0] ra, input logic [31:0] d);
      wb_valid = 1'b1;
      wb_pc    = pc;
      wb_waddr = ra;
      wb_wdata = d;
      tick();
      wb_valid = 1'b0;
   endtask

   task automatic do_arm(input logic m, input logic te, input logic [31:0] tpc);
      mode    = m;
      trig_en = te;
      trig_pc = tpc;
      arm     = 1'b1;
      tick();
      arm     = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_d);
      trace_entry_t e;
      check({tag, "_valid"}, 64'(rd_valid), 64'd1);
      e = rd_data;
      check({tag, "_pc"}, 64'(e.pc), 64'(exp_pc));
      check({tag, "_data"}, 64'(e.wdata), 64'(exp_d));
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
   endtask

   initial begin
      // Asynchronous reset visible before any clock edge.
      #2;
      check("rst_state", 64'(state), 64'(IDLE));
      check("rst_count", 64'(count), 64'd0);
      check("rst_valid", 64'(rd_valid), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      #10 rst = 1'b0;
      tick();

      // Linear, immediate trigger; the event in the arm cycle is not recorded.
      wb_valid = 1'b1; wb_pc = 32'h300; wb_waddr = 5'd9; wb_wdata = 32'h99;
      do_arm(1'b0, 1'b0, 32'h0);
      wb_valid = 1'b0;
      check("lin_armed", 64'(state), 64'(ARMED));
      for (int i = 1; i <= 6; i++) ev(32'h100 + 32'(4 * i), 5'(i), 32'(8'h11 * i));
      check("lin_done", 64'(state), 64'(DONE));
      check("lin_count", 64'(count), 64'd4);
      check("lin_ovf", 64'(overflow), 64'd0);
      pop_check("lin_r0", 32'h104, 32'h11);
      pop_check("lin_r1", 32'h108, 32'h22);
      pop_check("lin_r2", 32'h10C, 32'h33);
      pop_check("lin_r3", 32'h110, 32'h44);
      check("lin_empty_valid", 64'(rd_valid), 64'd0);
      check("lin_empty_state", 64'(state), 64'(DONE));

      // Linear with PC trigger; an x0 write at trig_pc neither records nor triggers.
      do_arm(1'b0, 1'b1, 32'h10);
      ev(32'h08, 5'd1, 32'hA1);
      ev(32'h10, 5'd0, 32'hA0);
      check("x0_state", 64'(state), 64'(ARMED));
      check("x0_count", 64'(count), 64'd0);
      ev(32'h0C, 5'd2, 32'hA2);
      ev(32'h10, 5'd3, 32'hA3);
      ev(32'h14, 5'd4, 32'hA4);
      check("trg_state", 64'(state), 64'(CAPTURE));
      check("trg_count", 64'(count), 64'd2);
      check("trg_valid", 64'(rd_valid), 64'd0);
      ev(32'h18, 5'd5, 32'hA5);
      ev(32'h1C, 5'd6, 32'hA6);
      check("trg_done", 64'(state), 64'(DONE));
      pop_check("trg_r0", 32'h10, 32'hA3);
      pop_check("trg_r1", 32'h14, 32'hA4);

      // Circular: six pre-trigger events, trigger, two post events.
      do_arm(1'b1, 1'b1, 32'h20);
      for (int i = 1; i <= 6; i++) ev(32'h40 + 32'(4 * i), 5'(i), 32'hB0 + 32'(i));
      check("circ_pre_state", 64'(state), 64'(ARMED));
      check("circ_pre_count", 64'(count), 64'd4);
      check("circ_pre_ovf", 64'(overflow), 64'd1);
      ev(32'h20, 5'd7, 32'hC0);
      check("circ_cap", 64'(state), 64'(CAPTURE));
      ev(32'h60, 5'd8, 32'hD1);
      check("circ_post1", 64'(state), 64'(CAPTURE));
      ev(32'h64, 5'd9, 32'hD2);
      check("circ_done", 64'(state), 64'(DONE));
      check("circ_count", 64'(count), 64'd4);
      check("circ_ovf", 64'(overflow), 64'd1);
      pop_check("circ_r0", 32'h58, 32'hB6);
      pop_check("circ_r1", 32'h20, 32'hC0);
      pop_check("circ_r2", 32'h60, 32'hD1);
      pop_check("circ_r3", 32'h64, 32'hD2);

      // Arm beats a simultaneous pop.
      do_arm(1'b0, 1'b0, 32'h0);
      check("arm_ovf_clr", 64'(overflow), 64'd0);
      for (int i = 1; i <= 4; i++) ev(32'h200 + 32'(4 * i), 5'(i), 32'hE0 + 32'(i));
      pop_check("ap_r0", 32'h204, 32'hE1);
      check("ap_count3", 64'(count), 64'd3);
      rd_ready = 1'b1;
      do_arm(1'b0, 1'b0, 32'h0);
      rd_ready = 1'b0;
      check("ap_state", 64'(state), 64'(ARMED));
      check("ap_count", 64'(count), 64'd0);
      check("ap_valid", 64'(rd_valid), 64'd0);

      // Asynchronous reset mid-capture, between clock edges.
      ev(32'h300, 5'd1, 32'hF1);
      ev(32'h304, 5'd2, 32'hF2);
      check("mr_cap", 64'(state), 64'(CAPTURE));
      check("mr_count2", 64'(count), 64'd2);
      #3 rst = 1'b1;
      #1;
      check("mr_state", 64'(state), 64'(IDLE));
      check("mr_count", 64'(count), 64'd0);
      #2 rst = 1'b0;
      ev(32'h308, 5'd3, 32'hF3);
      ev(32'h30C, 5'd4, 32'hF4);
      check("mr_idle", 64'(state), 64'(IDLE));
      check("mr_idle_count", 64'(count), 64'd0);
      check("mr_idle_valid", 64'(rd_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
